run_control: RTL and testbench
==============================

# run_control

Parametrised run-control and cycle-accounting unit that sits between the top-level enable and the processor core. It gates the core's execute enable and counts executed cycles on a wrap-flagged counter. It stops the core on a HLT instruction, on a PC breakpoint, or after a single step, and reports the halt cause. It generalises the former fixed 16-bit `cc` / `halt` pair into a configurable, debuggable run controller.

## Interface
- `CC_WIDTH`, 16, cycle-counter width (≥2)
- `ADDR_WIDTH`, 8, program-counter width
- `BP_COUNT`, 2, number of PC breakpoint comparators (≥1); `BP_IDX_W` = max(1, $clog2(BP_COUNT))
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `en` in 1 — run enable from top level (level)
- `step_req` in 1 — single-step request (pulse)
- `resume` in 1 — leave HALTED and run (pulse)
- `clr_cc` in 1 — synchronous clear of `cc` and `cc_wrap`
- `halt_in` in 1 — core has executed HLT
- `pc` in ADDR_WIDTH — core's current program counter
- `bp_addr` in BP_COUNT*ADDR_WIDTH — breakpoint addresses; slice i is comparator i
- `bp_valid` in BP_COUNT — per-comparator enable
- `core_en` out 1 — execute enable to core (combinational)
- `halt` out 1 — core stopped by HLT, breakpoint or step
- `halt_cause` out 2 — 0 NONE, 1 HLT, 2 BP, 3 STEP
- `halt_bp_idx` out BP_IDX_W — index of the breakpoint that hit
- `cc` out CC_WIDTH — executed-cycle count
- `cc_wrap` out 1 — sticky counter-overflow flag

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset enters IDLE.
- `bp_hit` = any i with `bp_valid[i]` and `pc == bp_addr[i]`, excluding the first RUN cycle after `resume` (skip flag). The lowest matching index wins.
- `core_en` = (RUN and !`bp_hit`) or STEP.
- IDLE:
  - `en`=1 → RUN.
  - Else `step_req`=1 → STEP.
  - `halt`=0, `halt_cause`=NONE.
- RUN, in priority order:
  - `en`=0 → IDLE.
  - `halt_in` → HALTED, cause HLT.
  - `bp_hit` → HALTED, cause BP, latch `halt_bp_idx`. The breakpointed instruction is not executed.
- STEP:
  - Exactly one cycle with `core_en`=1; breakpoints are ignored.
  - Next state is HALTED with cause STEP.
  - If `halt_in` is sampled in the STEP cycle, the cause is HLT.
- HALTED (`halt`=1), in priority order:
  - `en`=0 → IDLE; `halt` and cause are cleared.
  - `step_req` → STEP.
  - `resume` → RUN with the skip flag set, so execution proceeds past the breakpoint PC.
  - `step_req` and `resume` together: step wins.
- Counter:
  - `cc` increments by 1 each cycle `core_en`=1, modulo 2^CC_WIDTH.
  - On the all-ones → 0 transition, `cc_wrap` is set (sticky).
  - `clr_cc` forces `cc`=0 and `cc_wrap`=0 and beats a coincident increment.
  - The counter is not cleared by IDLE, HALTED or `en`.
- Reset mid-operation aborts immediately: state IDLE, all registered outputs at their reset values.

## Timing
- Reset values: `halt`=0, `halt_cause`=0, `halt_bp_idx`=0, `cc`=0, `cc_wrap`=0, skip=0. `core_en`=0 because the state is IDLE.
- All outputs except `core_en` are registered and change one cycle after the causing event.
- `core_en` is combinational from state, `pc`, breakpoint inputs and skip. A breakpoint blocks execution in the same cycle the PC matches.
- `en` rising in IDLE → `core_en`=1 on the next cycle.
- Halt event at edge N → `halt`=1 after edge N+1; `core_en`=0 from edge N+1 (from edge N for breakpoints).
- Single step produces exactly one `cc` increment.
- Pulses (`step_req`, `resume`) are sampled only in the states listed above and are ignored elsewhere.

## Structure
- Shared package `run_control_pkg`:
  - state enum `rc_state_t` {IDLE, RUN, STEP, HALTED}
  - cause constants `CAUSE_NONE/HLT/BP/STEP`
  - cause width `CAUSE_W`=2
- One sub-module `bp_match`: parametrised comparator array plus priority encoder, outputs `hit` and `idx`.
- Counter and FSM live in `run_control`.

## Test plan
- Reset, then `en`=1 for 10 cycles, then `en`=0 → `cc`=10, `halt`=0, state IDLE.
- `bp_addr[0]`=8'h05 valid, run from pc 0 → `core_en`=0 when `pc`=5, `halt`=1, `halt_cause`=2, `halt_bp_idx`=0. Pulse `resume` → pc 5 executes and `cc` continues.
- From HALTED, `step_req` three times → `cc` increases by exactly 3, `halt_cause`=3 after each step. Step onto a breakpoint PC → no BP halt.
- CC_WIDTH=4, run 17 cycles → `cc`=1, `cc_wrap`=1. `clr_cc` coincident with an increment → `cc`=0, `cc_wrap`=0.
- `halt_in` and `bp_hit` in the same RUN cycle → `halt_cause`=1. Breakpoints 0 and 1 both at 8'h03 → `halt_bp_idx`=0.
- Assert `rst` asynchronously while in RUN with `cc`=7 → all outputs zero immediately, `core_en`=0, state IDLE.

Source files
------------

// File: rtl/run_control_pkg.sv
// Shared types and constants for the run-control unit.
package run_control_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALTED
    } rc_state_t;

    localparam int CAUSE_W = 2;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_HLT  = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_BP   = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP = 2'd3;

endpackage

// File: rtl/run_control_bp_match.sv
// PC breakpoint comparator array with lowest-index-wins priority encoding.
module bp_match #(
    parameter int ADDR_WIDTH = 8,
    parameter int BP_COUNT   = 2,
    parameter int BP_IDX_W   = 1
) (
    input  logic [ADDR_WIDTH-1:0]          pc,
    input  logic [BP_COUNT*ADDR_WIDTH-1:0] bp_addr,
    input  logic [BP_COUNT-1:0]            bp_valid,
    output logic                           hit,
    output logic [BP_IDX_W-1:0]            idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < BP_COUNT; i++) begin
            if (!hit && bp_valid[i] && (pc == bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = BP_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// Run controller: gates core execution, counts executed cycles and records
// why the core stopped (HLT, breakpoint or single step).
module run_control
    import run_control_pkg::*;
#(
    parameter int  CC_WIDTH   = 16,
    parameter int  ADDR_WIDTH = 8,
    parameter int  BP_COUNT   = 2,
    localparam int BP_IDX_W   = (BP_COUNT > 1) ? $clog2(BP_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           step_req,
    input  logic                           resume,
    input  logic                           clr_cc,
    input  logic                           halt_in,
    input  logic [ADDR_WIDTH-1:0]          pc,
    input  logic [BP_COUNT*ADDR_WIDTH-1:0] bp_addr,
    input  logic [BP_COUNT-1:0]            bp_valid,
    output logic                           core_en,
    output logic                           halt,
    output logic [CAUSE_W-1:0]             halt_cause,
    output logic [BP_IDX_W-1:0]            halt_bp_idx,
    output logic [CC_WIDTH-1:0]            cc,
    output logic                           cc_wrap
);

    rc_state_t             r_state;
    logic                  r_skip;
    logic                  r_halt;
    logic [CAUSE_W-1:0]    r_cause;
    logic [BP_IDX_W-1:0]   r_bp_idx;
    logic [CC_WIDTH-1:0]   r_cc;
    logic                  r_wrap;

    logic                  w_match_hit;
    logic [BP_IDX_W-1:0]   w_match_idx;
    logic                  w_bp_hit;

    bp_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BP_COUNT   (BP_COUNT),
        .BP_IDX_W   (BP_IDX_W)
    ) u_bp_match (
        .pc       (pc),
        .bp_addr  (bp_addr),
        .bp_valid (bp_valid),
        .hit      (w_match_hit),
        .idx      (w_match_idx)
    );

    // The skip flag lets the instruction sitting on the breakpoint PC run once after resume.
    assign w_bp_hit = w_match_hit && (r_state == RUN) && !r_skip;
    assign core_en  = ((r_state == RUN) && !w_bp_hit) || (r_state == STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_skip   <= 1'b0;
            r_halt   <= 1'b0;
            r_cause  <= CAUSE_NONE;
            r_bp_idx <= '0;
        end else begin
            r_skip <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_halt  <= 1'b0;
                    r_cause <= CAUSE_NONE;
                    if (en) begin
                        r_state <= RUN;
                    end else if (step_req) begin
                        r_state <= STEP;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_halt  <= 1'b0;
                        r_cause <= CAUSE_NONE;
                    end else if (halt_in) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                        r_cause <= CAUSE_HLT;
                    end else if (w_bp_hit) begin
                        r_state  <= HALTED;
                        r_halt   <= 1'b1;
                        r_cause  <= CAUSE_BP;
                        r_bp_idx <= w_match_idx;
                    end
                end
                STEP: begin
                    r_state <= HALTED;
                    r_halt  <= 1'b1;
                    r_cause <= halt_in ? CAUSE_HLT : CAUSE_STEP;
                end
                HALTED: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_halt  <= 1'b0;
                        r_cause <= CAUSE_NONE;
                    end else if (step_req) begin
                        r_state <= STEP;
                        r_halt  <= 1'b0;
                        r_cause <= CAUSE_NONE;
                    end else if (resume) begin
                        r_state <= RUN;
                        r_skip  <= 1'b1;
                        r_halt  <= 1'b0;
                        r_cause <= CAUSE_NONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc   <= '0;
            r_wrap <= 1'b0;
        end else if (clr_cc) begin
            r_cc   <= '0;
            r_wrap <= 1'b0;
        end else if (core_en) begin
            r_cc <= r_cc + CC_WIDTH'(1);
            if (&r_cc) begin
                r_wrap <= 1'b1;
            end
        end
    end

    assign halt        = r_halt;
    assign halt_cause  = r_cause;
    assign halt_bp_idx = r_bp_idx;
    assign cc          = r_cc;
    assign cc_wrap     = r_wrap;

endmodule

// File: tb/tb_run_control.sv
// Randomized and directed bench for run_control against a behavioural model.
module tb_run_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, step_req = 1'b0, resume = 1'b0, clr_cc = 1'b0, halt_in = 1'b0;
    logic [7:0]  pc = '0;
    logic [15:0] bp_addr = '0;
    logic [1:0]  bp_valid = '0;
    logic        core_en, halt, cc_wrap;
    logic [1:0]  halt_cause;
    logic [0:0]  halt_bp_idx;
    logic [3:0]  cc;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    string m_mode = "idle";
    bit    m_skip = 0;
    bit    m_halt = 0;
    int    m_cause = 0;
    int    m_idx = 0;
    int    m_total = 0;
    bit    m_hit;
    int    m_hit_idx;
    bit    m_core_en;
    bit    auto_pc = 1;

    run_control #(
        .CC_WIDTH   (4),
        .ADDR_WIDTH (8),
        .BP_COUNT   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .step_req    (step_req),
        .resume      (resume),
        .clr_cc      (clr_cc),
        .halt_in     (halt_in),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .core_en     (core_en),
        .halt        (halt),
        .halt_cause  (halt_cause),
        .halt_bp_idx (halt_bp_idx),
        .cc          (cc),
        .cc_wrap     (cc_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = "idle";
        m_skip  = 0;
        m_halt  = 0;
        m_cause = 0;
        m_idx   = 0;
        m_total = 0;
    endtask

    task automatic model_comb();
        m_hit = 0;
        m_hit_idx = 0;
        for (int i = 0; i < 2; i++) begin
            if (!m_hit && bp_valid[i] && pc == bp_addr[i*8 +: 8]) begin
                m_hit = 1;
                m_hit_idx = i;
            end
        end
        if (m_mode != "run" || m_skip) m_hit = 0;
        m_core_en = (m_mode == "run" && !m_hit) || (m_mode == "step");
    endtask

    task automatic model_update();
        string nxt;
        bit    nskip;
        if (rst) begin
            model_reset();
            return;
        end
        nxt = m_mode;
        nskip = 0;
        if (m_mode == "idle") begin
            m_halt = 0; m_cause = 0;
            if (en) nxt = "run";
            else if (step_req) nxt = "step";
        end else if (m_mode == "run") begin
            if (!en) begin nxt = "idle"; m_halt = 0; m_cause = 0; end
            else if (halt_in) begin nxt = "halted"; m_halt = 1; m_cause = 1; end
            else if (m_hit) begin nxt = "halted"; m_halt = 1; m_cause = 2; m_idx = m_hit_idx; end
        end else if (m_mode == "step") begin
            nxt = "halted"; m_halt = 1; m_cause = halt_in ? 1 : 3;
        end else begin
            if (!en) begin nxt = "idle"; m_halt = 0; m_cause = 0; end
            else if (step_req) begin nxt = "step"; m_halt = 0; m_cause = 0; end
            else if (resume) begin nxt = "run"; nskip = 1; m_halt = 0; m_cause = 0; end
        end
        if (clr_cc) m_total = 0;
        else if (m_core_en) m_total++;
        m_mode = nxt;
        m_skip = nskip;
    endtask

    // One clock: check combinational enable, advance, check registered outputs.
    task automatic tick();
        #1;
        model_comb();
        check("core_en", core_en, m_core_en);
        @(posedge clk);
        model_update();
        #1;
        check("halt", halt, m_halt);
        check("halt_cause", halt_cause, m_cause);
        check("halt_bp_idx", halt_bp_idx, m_idx);
        check("cc", cc, m_total % 16);
        check("cc_wrap", cc_wrap, m_total >= 16);
        if (auto_pc && m_core_en) pc = pc + 8'd1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_core_en", core_en, 0);
        check("rst_halt", halt, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_idx", halt_bp_idx, 0);
        check("rst_cc", cc, 0);
        check("rst_wrap", cc_wrap, 0);
        rst = 0;

        // Ten enabled cycles, then disable.
        en = 1;
        repeat (10) tick();
        en = 0;
        tick();
        check("run10_cc", cc, 10);
        check("run10_halt", halt, 0);
        #1 check("run10_idle_core_en", core_en, 0);

        // Breakpoint at 5 then resume past it.
        clr_cc = 1; pc = 0; bp_addr = 16'h0005; bp_valid = 2'b01;
        tick();
        clr_cc = 0; en = 1;
        for (int i = 0; i < 30 && m_mode != "halted"; i++) tick();
        check("bp_halt", halt, 1);
        check("bp_cause", halt_cause, 2);
        check("bp_idx", halt_bp_idx, 0);
        #1 check("bp_blocks", core_en, 0);
        resume = 1; tick(); resume = 0;
        tick();
        check("resume_cc", cc, 6);

        // HLT, then three single steps, one landing on a breakpoint PC.
        halt_in = 1; tick(); halt_in = 0;
        check("hlt_cause", halt_cause, 1);
        bp_addr = {8'd8, 8'd5}; bp_valid = 2'b11;
        for (int s = 0; s < 3; s++) begin
            step_req = 1; tick(); step_req = 0;
            tick();
            check("step_cause", halt_cause, 3);
        end
        check("step_cc", cc, 10);

        // Wrap on a 4-bit counter, then clear beating an increment.
        en = 0; tick();
        bp_valid = 2'b00; clr_cc = 1; en = 1; tick();
        clr_cc = 0;
        repeat (17) tick();
        check("wrap_cc", cc, 1);
        check("wrap_flag", cc_wrap, 1);
        clr_cc = 1; tick(); clr_cc = 0;
        check("clr_cc", cc, 0);
        check("clr_wrap", cc_wrap, 0);

        // HLT beats BP; lowest index wins; upper comparator alone.
        auto_pc = 0;
        bp_addr = {8'd3, 8'd3}; bp_valid = 2'b11;
        pc = 3; halt_in = 1; tick(); halt_in = 0;
        check("hlt_over_bp", halt_cause, 1);
        en = 0; tick();
        en = 1; pc = 0; tick();
        pc = 3; tick();
        check("dual_bp_cause", halt_cause, 2);
        check("dual_bp_idx", halt_bp_idx, 0);
        bp_valid = 2'b10;
        resume = 1; tick(); resume = 0;
        tick();
        pc = 4; tick();
        pc = 3; tick();
        check("bp1_cause", halt_cause, 2);
        check("bp1_idx", halt_bp_idx, 1);
        auto_pc = 1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom % 100) < 92;
            step_req = ($urandom % 100) < 10;
            resume   = ($urandom % 100) < 15;
            clr_cc   = ($urandom % 100) < 3;
            halt_in  = ($urandom % 100) < 5;
            if (c % 16 == 0) begin
                bp_addr  = {8'($urandom % 8), 8'($urandom % 8)};
                bp_valid = 2'($urandom);
            end
            if ($urandom % 8 == 0) pc = 8'($urandom % 8);
            else pc = pc & 8'h07;
            tick();
        end
        step_req = 0; resume = 0; clr_cc = 0; halt_in = 0;

        // Asynchronous reset while running with cc=7.
        en = 0; tick();
        bp_valid = 2'b00; clr_cc = 1; en = 1; tick();
        clr_cc = 0;
        repeat (7) tick();
        check("pre_rst_cc", cc, 7);
        #2 rst = 1;
        #1;
        check("arst_core_en", core_en, 0);
        check("arst_halt", halt, 0);
        check("arst_cause", halt_cause, 0);
        check("arst_idx", halt_bp_idx, 0);
        check("arst_cc", cc, 0);
        check("arst_wrap", cc_wrap, 0);
        model_reset();
        tick();
        rst = 0; en = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
